// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search helper for the mux arbiter.
// rr_pick works on a fixed maximum width so one function serves any N up to MAX_N.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MAX_N  = 32;
  localparam int MAX_SW = 5;

  typedef struct packed {
    logic              found;
    logic [MAX_SW-1:0] idx;
  } pick_t;

  // First set bit of req[n-1:0], scanning ptr, ptr+1, ... with wrap-around at n.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input int unsigned      ptr,
                                    input int unsigned      n);
    pick_t       p;
    int unsigned i;
    p = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        i = ptr + k;
        if (i >= n) i = i - n;
        if (!p.found && req[i[MAX_SW-1:0]]) begin
          p.found = 1'b1;
          p.idx   = i[MAX_SW-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Purely combinational N-way word multiplexer; an out-of-range select yields zero.
module mux_nto1 #(
  parameter  int N  = 4,
  parameter  int DW = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N*DW-1:0] i_data,
  input  logic [SW-1:0]   i_sel,
  output logic [DW-1:0]   o_data
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < N; k++) begin
      if (i_sel == SW'(k)) o_data = i_data[k*DW +: DW];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared N-way mux onto one valid/ready port.
// Optional burst lock: define MUX_ARB_LOCK_EN to add the lock input.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [DW-1:0]   out_data,
  output logic [SW-1:0]   out_sel,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack
);

  state_t          r_state, w_next_state;
  logic [N-1:0]    r_gnt, w_next_gnt;
  logic [SW-1:0]   r_sel, w_next_sel;
  logic [SW-1:0]   r_ptr, w_next_ptr;
  logic [SW-1:0]   w_ptr_inc;
  logic            w_hs;
  logic            w_keep;
  logic [MAX_N-1:0] w_scan_req;
  logic [SW-1:0]   w_scan_ptr;
  pick_t           w_pick;
  logic [SW-1:0]   w_pick_sel;
  logic [N-1:0]    w_pick_gnt;

  always_comb begin : arb_search
    w_hs       = (r_state == BUSY) && out_ready;
    w_ptr_inc  = (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;
`ifdef MUX_ARB_LOCK_EN
    w_keep     = lock[r_sel] & req[r_sel];
`else
    w_keep     = 1'b0;
`endif
    // In BUSY the search runs for the handshake: the winner is masked and the scan starts past it.
    w_scan_req = '0;
    if (r_state == IDLE) begin
      w_scan_req[N-1:0] = req;
      w_scan_ptr        = r_ptr;
    end else begin
      w_scan_req[N-1:0] = req & ~r_gnt;
      w_scan_ptr        = w_ptr_inc;
    end
    w_pick     = rr_pick(w_scan_req, 32'(w_scan_ptr), N);
    w_pick_sel = w_pick.idx[SW-1:0];
    w_pick_gnt = N'(1) << w_pick_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= w_next_gnt;
      r_sel   <= w_next_sel;
      r_ptr   <= w_next_ptr;
    end
  end

  always_comb begin : next_state_logic
    // NOTE: every signal in this block is defaulted first, so no branch can infer a latch.
    w_next_state = r_state;
    w_next_gnt   = r_gnt;
    w_next_sel   = r_sel;
    w_next_ptr   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_next_state = BUSY;
          w_next_sel   = w_pick_sel;
          w_next_gnt   = w_pick_gnt;
        end
      end
      BUSY: begin
        // A locked burst keeps grant and pointer untouched across the handshake.
        if (w_hs && !w_keep) begin
          w_next_ptr = w_ptr_inc;
          if (w_pick.found) begin
            w_next_sel = w_pick_sel;
            w_next_gnt = w_pick_gnt;
          end else begin
            w_next_state = IDLE;
            w_next_gnt   = '0;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin : output_logic
    out_valid = (r_state == BUSY);
    gnt       = r_gnt;
    out_sel   = r_sel;
    ack       = w_hs ? r_gnt : '0;
  end

  mux_nto1 #(
    .N  (N),
    .DW (DW)
  ) u_mux (
    .i_data (in_data),
    .i_sel  (r_sel),
    .o_data (out_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level round-robin model.
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] in_data;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic [N-1:0]    lock_v = '0;

  mux_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock_v),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .gnt       (gnt),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the port, where the round-robin scan starts.
  bit  m_busy;
  int  m_sel;
  int  m_ptr;
  int  last_ack;
  int  wait_cnt [N];
  bit  fair_en = 1'b1;

  logic [N-1:0]  r_req;
  logic [DW-1:0] r_dat [N];

  function automatic int scan(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic apply();
    req = r_req;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = r_dat[i];
  endtask

  task automatic compare_outputs(input string tag);
    logic [N-1:0] exp_gnt;
    exp_gnt = m_busy ? N'(1) << m_sel : '0;
    check({tag, ".valid"}, 32'(out_valid), 32'(m_busy));
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".ack"}, 32'(ack), 32'((m_busy && out_ready) ? exp_gnt : '0));
    if (m_busy) begin
      check({tag, ".sel"}, 32'(out_sel), 32'(m_sel));
      check({tag, ".data"}, 32'(out_data), 32'(in_data[m_sel*DW +: DW]));
    end
  endtask

  task automatic model_edge();
    int           nxt;
    logic [N-1:0] masked;
    last_ack = -1;
    if (!m_busy) begin
      nxt = scan(req, m_ptr);
      if (nxt >= 0) begin
        m_busy = 1'b1;
        m_sel  = nxt;
      end
    end else if (out_ready) begin
      last_ack = m_sel;
      if (!(lock_v[m_sel] && req[m_sel])) begin
        for (int i = 0; i < N; i++) begin
          if (i == m_sel) begin
            if (fair_en) check("fair", 32'(wait_cnt[i] <= N), 32'd1);
            wait_cnt[i] = 0;
          end else if (req[i]) wait_cnt[i]++;
          else wait_cnt[i] = 0;
        end
        m_ptr  = (m_sel + 1) % N;
        masked = req;
        masked[m_sel] = 1'b0;
        nxt = scan(masked, m_ptr);
        if (nxt >= 0) m_sel = nxt;
        else m_busy = 1'b0;
      end
    end
  endtask

  task automatic half(input string tag);
    @(negedge clk);
    compare_outputs(tag);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick(input string tag);
    half(tag);
    edge_step();
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_sel    = 0;
    m_ptr    = 0;
    last_ack = -1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Asserts reset asynchronously, checks the cleared outputs, releases after one edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    r_req = '0;
    lock_v = '0;
    apply();
    #1;
    check({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".rst_gnt"}, 32'(gnt), 32'd0);
    check({tag, ".rst_ack"}, 32'(ack), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (r_req[i]) begin
        if (last_ack == i) begin
          if ($urandom_range(0, 1) == 0) r_req[i] = 1'b0;
          r_dat[i] = DW'($urandom);
        end
      end else if ($urandom_range(0, 9) < 3) begin
        r_req[i] = 1'b1;
        r_dat[i] = DW'($urandom);
      end
    end
    out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_LOCK_EN
    lock_v = N'($urandom & $urandom);
`endif
    apply();
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    r_req     = '0;
    for (int i = 0; i < N; i++) r_dat[i] = DW'($urandom);
    apply();
    model_reset();
    #2;
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.gnt", 32'(gnt), 32'd0);
    check("reset.ack", 32'(ack), 32'd0);
    check("reset.sel", 32'(out_sel), 32'd0);
    check("reset.data", 32'(out_data), 32'(r_dat[0]));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request: one-cycle latency, ack, then the pointer moves to 1.
    do_reset("s1");
    r_req[0] = 1'b1; r_dat[0] = 8'hA5; out_ready = 1'b1;
    apply();
    half("s1a"); check("s1.idle_valid", 32'(out_valid), 32'd0); edge_step();
    half("s1b");
    check("s1.valid", 32'(out_valid), 32'd1);
    check("s1.data", 32'(out_data), 32'hA5);
    check("s1.gnt", 32'(gnt), 32'b0001);
    check("s1.ack", 32'(ack), 32'b0001);
    edge_step();
    r_req = '0; apply();
    half("s1c"); check("s1.back_idle", 32'(out_valid), 32'd0); edge_step();
    r_req = 4'b0011; apply();
    tick("s1d");
    half("s1e"); check("s1.ptr1_gnt", 32'(gnt), 32'b0010); edge_step();
    r_req = '0; apply();
    tick("s1f"); tick("s1g");

    // Rotation with all requesters active: 0,1,2,3,0 back to back.
    do_reset("s2");
    r_req = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) r_dat[i] = DW'(i);
    apply();
    tick("s2a");
    for (int k = 0; k < 5; k++) begin
      half("s2b");
      check("s2.valid", 32'(out_valid), 32'd1);
      check("s2.data", 32'(out_data), 32'(k % N));
      check("s2.gnt", 32'(gnt), 32'(1 << (k % N)));
      edge_step();
    end
    r_req = '0; apply();
    tick("s2c"); tick("s2d");

    // Backpressure: five stalled cycles, then one ack.
    do_reset("s3");
    r_req[2] = 1'b1; r_dat[2] = 8'h3C; out_ready = 1'b0;
    apply();
    tick("s3a");
    for (int k = 0; k < 5; k++) begin
      half("s3b");
      check("s3.valid", 32'(out_valid), 32'd1);
      check("s3.data", 32'(out_data), 32'h3C);
      check("s3.gnt", 32'(gnt), 32'b0100);
      check("s3.no_ack", 32'(ack), 32'd0);
      edge_step();
    end
    out_ready = 1'b1; apply();
    half("s3c"); check("s3.ack", 32'(ack), 32'b0100); edge_step();
    r_req = '0; apply();
    half("s3d"); check("s3.after_ack", 32'(ack), 32'd0); edge_step();

    // Wrap-around: pointer at 3, requesters 3 and 0 alternate.
    do_reset("s4");
    r_req[2] = 1'b1; out_ready = 1'b1; apply();
    tick("s4a"); tick("s4b");
    r_req = 4'b1001; apply();
    tick("s4c");
    half("s4d"); check("s4.gnt3", 32'(gnt), 32'b1000); edge_step();
    half("s4e"); check("s4.gnt0", 32'(gnt), 32'b0001); edge_step();
    r_req = '0; apply();
    tick("s4f"); tick("s4g");

    // Reset in the middle of a stalled transfer.
    do_reset("s5");
    r_req[1] = 1'b1; out_ready = 1'b0; apply();
    tick("s5a");
    half("s5b"); check("s5.gnt1", 32'(gnt), 32'b0010); edge_step();
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("s5.async_valid", 32'(out_valid), 32'd0);
    check("s5.async_gnt", 32'(gnt), 32'd0);
    check("s5.async_ack", 32'(ack), 32'd0);
    model_reset();
    r_req = 4'b0011; apply();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("s5c");
    half("s5d"); check("s5.scan_from0", 32'(gnt), 32'b0001); edge_step();
    r_req = '0; apply();
    tick("s5e"); tick("s5f");

`ifdef MUX_ARB_LOCK_EN
    // Burst lock: three words from requester 0, then requester 1.
    do_reset("s6");
    r_req = 4'b0011; lock_v = 4'b0001; out_ready = 1'b1; apply();
    tick("s6a");
    for (int k = 0; k < 3; k++) begin
      if (k == 2) lock_v = '0;
      half("s6b");
      check("s6.ack0", 32'(ack), 32'b0001);
      edge_step();
    end
    half("s6c"); check("s6.gnt1", 32'(gnt), 32'b0010); edge_step();
    r_req = '0; apply();
    tick("s6d"); tick("s6e");
    fair_en = 1'b0;
`endif

    // Randomized traffic with one asynchronous reset in the middle.
    do_reset("rnd");
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset("rnd_mid");
      drive_random();
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one N-way data multiplexer among N requesters.
- Grants one requester at a time and drives the mux select from a registered grant.
- Presents the selected word on a single valid/ready output port.
- Sits between several producers and one shared downstream consumer. It is the sequential controller for the team's mux datapath.

Parameters:
- N, 4, number of requesters (≥2).
- DW, 8, data width per requester.
- SW, $clog2(N), select width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester request; bit i belongs to requester i.
- in_data  in  N*DW  packed requester data; slice [i*DW +: DW] belongs to requester i.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DW  selected requester data.
- out_sel  out  SW  registered mux select (index of granted requester).
- gnt  out  N  one-hot grant, registered.
- ack  out  N  one-cycle pulse on the granted bit when the transfer completes.
- lock  in  N  per-requester grant lock. Present only with MUX_ARB_LOCK_EN.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, gnt=0, out_sel=0, out_valid=0, ack=0.
  - Priority pointer ptr=0.
  - out_data is a don't-care while out_valid=0; the implementation drives in_data slice 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req≠0, pick the first set bit scanning ptr, ptr+1, … modulo N (wrap-around).
  - Register gnt/out_sel and go to BUSY.
  - Latency: req high at edge k gives out_valid=1 after edge k+1 (1 cycle).
- BUSY:
  - out_valid=1.
  - out_data = in_data slice out_sel, combinational from the registered select.
  - gnt, out_sel and out_valid are held until out_valid & out_ready.
- Handshake cycle (out_valid & out_ready):
  - ack[out_sel]=1 for that cycle only.
  - ptr ← (out_sel+1) mod N.
  - If the remaining req bits, with the current winner's bit masked, are ≠0: re-arbitrate in the same cycle from the new ptr and stay in BUSY with the new grant. This gives back-to-back transfers, one word per cycle.
  - Otherwise go to IDLE.
  - The current winner's own req is masked for one cycle, so the same requester cannot win twice in a row while others wait.
  - A lone requester re-wins after one IDLE cycle.
- Requester rule:
  - Hold req and data stable from assertion until its ack pulse.
  - Deassert or re-arm req after ack.
  - A req that drops while granted is ignored: the grant persists until the handshake.
- Arbiter does not sample req bits of non-granted requesters except at arbitration points.
- out_ready may toggle arbitrarily. Stalls of any length hold all outputs stable.
- Reset asserted mid-transfer:
  - All outputs clear immediately (asynchronous).
  - The transfer is lost and no ack is issued.
  - ptr returns to 0.
- Fairness: any continuously asserting requester is granted within N transfers.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - lock port exists.
  - If lock[out_sel]=1 at a handshake and req[out_sel]=1, the arbiter keeps the same grant in BUSY.
  - ptr does not advance and ack still pulses.
  - Used for multi-word bursts. A lock on a non-granted requester has no effect.
- Undefined:
  - No lock port.
  - Pure round-robin as above.

Decomposition:
- Package mux_arb_pkg holds:
  - the state enum type (IDLE, BUSY);
  - a function rr_pick(req, ptr) returning the index and a found flag.
- One sub-module: mux_nto1 (parameters N, DW; pure combinational N-way mux on in_data by out_sel).
- Arbiter FSM, pointer and handshake logic live in mux_rr_arbiter.

Test Plan (all scenarios use N=4, DW=8):
- Reset and single request:
  - Stimulus: reset, then req=0001, in_data[7:0]=0xA5, out_ready=1.
  - Required: out_valid after 1 cycle; out_data=0xA5, gnt=0001, ack[0] pulse; then IDLE, ptr=1.
- Round-robin rotation:
  - Stimulus: req=1111 held, each requester's data = its index, out_ready=1.
  - Required: out_data sequence 0,1,2,3,0, back-to-back one per cycle; gnt rotates 0001→0010→0100→1000.
- Backpressure:
  - Stimulus: req=0100, data 0x3C, out_ready=0 for 5 cycles then 1.
  - Required: out_valid, out_data=0x3C and gnt=0100 stable for 5 cycles; single ack[2] on cycle 6.
- Wrap-around and masking:
  - Stimulus: ptr=3 (after a grant to 2), req=1001.
  - Required: grant 3, then 0; requester 3 is not granted twice consecutively.
- Reset mid-transfer:
  - Stimulus: BUSY with gnt=0010, out_ready=0; pulse rst_n low.
  - Required: out_valid=0, gnt=0 immediately; no ack; next grant scans from 0.
- Lock (MUX_ARB_LOCK_EN):
  - Stimulus: req=0011, lock[0]=1 for 3 words, out_ready=1.
  - Required: three acks on requester 0, then grant to 1.
